// File: rtl/oka_mac_acc.sv
// ---------------------------------------------------------------------------
// oka_mac_acc
//
// Purpose:
//   Accumulator stage that sits directly after the 32x32 Karatsuba
//   multiplier. It takes one 63-bit unsigned product per cycle under a
//   valid/ready handshake and adds together all beats of a frame. A frame
//   ends with the beat that has in_last set. When a frame ends, the stage
//   presents three registered results until downstream accepts them:
//   the frame sum, the number of beats, and an overflow flag.
//
// Parameters:
//   ACC_W  accumulator/result width in bits (must be >= 63)
//   CNT_W  beat-counter width
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   product beat valid
//   in_ready   out  stage can accept a beat (low while a result is held)
//   in_prod    in   63-bit unsigned product from the multiplier
//   in_last    in   final beat of the frame, qualified by in_valid
//   out_valid  out  frame result valid
//   out_ready  in   downstream accepts the result
//   out_sum    out  frame sum (ACC_W bits)
//   out_count  out  beats in the frame including the last (saturating)
//   out_ovf    out  the sum carried out of ACC_W bits during the frame
//
// Build option:
//   OKA_MAC_SAT_EN  When defined, a carry-out clamps the accumulator to its
//                   maximum value instead of wrapping. out_ovf is still set.
// ---------------------------------------------------------------------------
module oka_mac_acc #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [62:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic               accept;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     add_full;
  logic               add_carry;
  logic [ACC_W-1:0]   add_sum;
  logic [CNT_W-1:0]   cnt_inc;

  assign accept = in_valid && in_ready;

  // This block computes the next running sum and count.
  // The add is one bit wider than the accumulator so that the carry-out is
  // captured. In saturating builds, any carry clamps the sum to all ones.
  // Once the accumulator holds all ones, any further non-zero beat carries
  // again, so the value stays clamped for the rest of the frame.
  // The counter stops at its maximum value instead of wrapping back to zero.
  always_comb begin
    prod_ext  = ACC_W'(in_prod);
    add_full  = {1'b0, acc} + {1'b0, prod_ext};
    add_carry = add_full[ACC_W];
`ifdef OKA_MAC_SAT_EN
    add_sum   = add_carry ? '1 : add_full[ACC_W-1:0];
`else
    add_sum   = add_full[ACC_W-1:0];
`endif
    cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  // This is the frame FSM. in_ready is a registered copy of (state != HOLD).
  // It is updated on every state change, so it never depends
  // combinationally on the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_last) begin
              out_sum   <= prod_ext;
              out_count <= CNT_W'(1);
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end else begin
              acc   <= prod_ext;
              cnt   <= CNT_W'(1);
              ovf   <= 1'b0;
              state <= ACC;
            end
          end
        end

        ACC: begin
          if (accept) begin
            if (in_last) begin
              out_sum   <= add_sum;
              out_count <= cnt_inc;
              out_ovf   <= ovf | add_carry;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= add_sum;
              cnt <= cnt_inc;
              ovf <= ovf | add_carry;
            end
          end
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oka_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_oka_mac_acc
//
// Purpose:
//   Self-checking bench for oka_mac_acc. Two instances receive the same
//   input stream:
//     - a default-width instance (ACC_W=72, CNT_W=16)
//     - a narrow instance (ACC_W=64, CNT_W=2), used to exercise overflow
//       and count saturation
//   Whenever a frame's last beat is accepted, the expected result for each
//   instance is pushed into that instance's queue. Each queue has its own
//   monitor, which pops and compares whenever that instance hands over a
//   result.
//
// Ports: none.
// Build option: OKA_MAC_SAT_EN selects the saturating expectations.
// ---------------------------------------------------------------------------
module tb_oka_mac_acc;

  localparam int BIG_W = 72;
  localparam int BIG_C = 16;
  localparam int SM_W  = 64;
  localparam int SM_C  = 2;
  localparam logic [62:0] PMAX = '1;

  typedef struct {
    logic [71:0] sum;
    logic [15:0] count;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [62:0] in_prod = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [71:0] out_sum_b;
  logic [15:0] out_count_b;

  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [63:0] out_sum_s;
  logic [1:0]  out_count_s;

  int   errors = 0;
  int   checks = 0;
  bit   ready_random = 1'b0;
  exp_t q_b[$];
  exp_t q_s[$];

  oka_mac_acc #(.ACC_W(BIG_W), .CNT_W(BIG_C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  oka_mac_acc #(.ACC_W(SM_W), .CNT_W(SM_C)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_count(out_count_s), .out_ovf(out_ovf_s)
  );

  always #5 clk = ~clk;

  // Reference model for one whole frame, working from the true
  // (unbounded) total. The frame overflows when that total cannot fit in
  // w bits. The reported sum is then either the total wrapped to w bits or
  // the clamped maximum. The count is the number of beats, capped at
  // 2^c-1.
  function automatic exp_t model(input logic [62:0] beats[$], input int w, input int c);
    exp_t         r;
    logic [127:0] total;
    logic [127:0] maxv;
    int           cmax;
    total = '0;
    foreach (beats[i]) total += 128'(beats[i]);
    maxv  = (128'd1 << w) - 128'd1;
    r.ovf = (total > maxv);
`ifdef OKA_MAC_SAT_EN
    r.sum = 72'(r.ovf ? maxv : total);
`else
    r.sum = 72'(total & maxv);
`endif
    cmax    = (1 << c) - 1;
    r.count = 16'((beats.size() > cmax) ? cmax : beats.size());
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advances one clock; when enabled, also picks a new random out_ready.
  task automatic step();
    @(posedge clk);
    #1;
    if (ready_random) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offers one beat and holds it until an edge where the stage was ready.
  task automatic send_beat(input logic [62:0] p, input logic last);
    logic rdy;
    bit   accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      rdy = in_ready_b;
      step();
      accepted = rdy;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout: actual=not_accepted required=accepted");
    end
    in_valid = 1'b0;
    in_prod  = 63'({$urandom, $urandom});
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [62:0] beats[$], input int max_gap);
    for (int i = 0; i < beats.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      if (i == beats.size() - 1 && i > 0)
        checkOutput("mid_frame_out_valid", 128'(out_valid_b), 128'd0);
      send_beat(beats[i], (i == beats.size() - 1));
    end
    q_b.push_back(model(beats, BIG_W, BIG_C));
    q_s.push_back(model(beats, SM_W, SM_C));
    checkOutput("latency_out_valid", 128'(out_valid_b), 128'd1);
  endtask

  // Monitor and scoreboard for the default-width instance.
  always @(negedge clk) begin : mon_big
    exp_t e;
    if (!rst && out_valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL big_unexpected_result: actual=%0h required=none", out_sum_b);
      end else begin
        e = q_b.pop_front();
        checkOutput("big_sum", 128'(out_sum_b), 128'(e.sum));
        checkOutput("big_count", 128'(out_count_b), 128'(e.count));
        checkOutput("big_ovf", 128'(out_ovf_b), 128'(e.ovf));
      end
    end
  end

  // Monitor and scoreboard for the narrow instance.
  always @(negedge clk) begin : mon_small
    exp_t e;
    if (!rst && out_valid_s && out_ready) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL small_unexpected_result: actual=%0h required=none", out_sum_s);
      end else begin
        e = q_s.pop_front();
        checkOutput("small_sum", 128'(out_sum_s), 128'(e.sum));
        checkOutput("small_count", 128'(out_count_s), 128'(e.count));
        checkOutput("small_ovf", 128'(out_ovf_s), 128'(e.ovf));
      end
    end
  end

  initial begin
    logic [62:0] beats[$];
    logic [63:0] r;
    int          len;
    int          mode;

    // Values held during reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 128'(in_ready_b), 128'd1);
    checkOutput("reset_out_valid", 128'(out_valid_b), 128'd0);
    checkOutput("reset_out_sum", 128'(out_sum_b), 128'd0);
    checkOutput("reset_out_count", 128'(out_count_b), 128'd0);
    checkOutput("reset_out_ovf", 128'(out_ovf_b), 128'd0);
    checkOutput("reset_small_sum", 128'(out_sum_s), 128'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();

    // Single-beat frame carrying the largest product.
    $display("[TB] single-beat frame");
    beats.delete();
    beats.push_back(PMAX);
    applyStimulus(beats, 0);
    checkOutput("single_sum", 128'(out_sum_b), 128'h00_7FFF_FFFF_FFFF_FFFF);
    checkOutput("single_count", 128'(out_count_b), 128'd1);
    checkOutput("single_ovf", 128'(out_ovf_b), 128'd0);
    step();

    // Four beats with idle gaps, then the result is held under backpressure.
    $display("[TB] four-beat frame with backpressure");
    out_ready = 1'b0;
    beats.delete();
    beats.push_back(63'd3);
    beats.push_back(63'd5);
    beats.push_back(63'd7);
    beats.push_back(63'd11);
    applyStimulus(beats, 2);
    checkOutput("four_sum", 128'(out_sum_b), 128'd26);
    checkOutput("four_count", 128'(out_count_b), 128'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_prod  = 63'd99;
      step();
      checkOutput("bp_out_valid", 128'(out_valid_b), 128'd1);
      checkOutput("bp_in_ready", 128'(in_ready_b), 128'd0);
      checkOutput("bp_out_sum", 128'(out_sum_b), 128'd26);
      checkOutput("bp_out_count", 128'(out_count_b), 128'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("drain_out_valid", 128'(out_valid_b), 128'd0);
    checkOutput("drain_in_ready", 128'(in_ready_b), 128'd1);
    checkOutput("drain_sum_held", 128'(out_sum_b), 128'd26);
    checkOutput("drain_count_held", 128'(out_count_b), 128'd4);

    // Three maximum products: this overflows 64 bits but not 72 bits.
    $display("[TB] overflow frame");
    beats.delete();
    repeat (3) beats.push_back(PMAX);
    applyStimulus(beats, 1);
`ifdef OKA_MAC_SAT_EN
    checkOutput("ovf_small_sum", 128'(out_sum_s), 128'hFFFF_FFFF_FFFF_FFFF);
`else
    checkOutput("ovf_small_sum", 128'(out_sum_s), 128'h7FFF_FFFF_FFFF_FFFD);
`endif
    checkOutput("ovf_small_flag", 128'(out_ovf_s), 128'd1);
    checkOutput("ovf_big_sum", 128'(out_sum_b), 128'h01_7FFF_FFFF_FFFF_FFFD);
    checkOutput("ovf_big_flag", 128'(out_ovf_b), 128'd0);
    step();

    // Five beats: the 2-bit counter stops at 3.
    $display("[TB] count saturation frame");
    beats.delete();
    repeat (5) beats.push_back(63'd1);
    applyStimulus(beats, 1);
    checkOutput("csat_small_count", 128'(out_count_s), 128'd3);
    checkOutput("csat_small_sum", 128'(out_sum_s), 128'd5);
    checkOutput("csat_small_ovf", 128'(out_ovf_s), 128'd0);
    checkOutput("csat_big_count", 128'(out_count_b), 128'd5);
    step();

    // Reset arrives after two beats of a frame; the partial frame is dropped.
    $display("[TB] reset mid-frame");
    send_beat(63'd40, 1'b0);
    send_beat(63'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 128'(in_ready_b), 128'd1);
    checkOutput("midrst_out_valid", 128'(out_valid_b), 128'd0);
    checkOutput("midrst_out_sum", 128'(out_sum_b), 128'd0);
    checkOutput("midrst_out_count", 128'(out_count_b), 128'd0);
    #2 rst = 1'b0;
    step();
    beats.delete();
    beats.push_back(63'd10);
    beats.push_back(63'd20);
    applyStimulus(beats, 1);
    checkOutput("after_reset_sum", 128'(out_sum_b), 128'd30);
    checkOutput("after_reset_count", 128'(out_count_b), 128'd2);

    // Random frames with random gaps and random out_ready.
    $display("[TB] random frames");
    ready_random = 1'b1;
    for (int f = 0; f < 40; f++) begin
      beats.delete();
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        mode = $urandom_range(0, 3);
        r    = {$urandom, $urandom};
        if (mode == 0)      beats.push_back(PMAX);
        else if (mode == 1) beats.push_back(63'(r[7:0]));
        else                beats.push_back(r[62:0]);
      end
      applyStimulus(beats, 2);
    end

    // Drain whatever is still held and confirm every expected result was seen.
    ready_random = 1'b0;
    out_ready    = 1'b1;
    repeat (4) step();
    checkOutput("big_queue_empty", 128'(q_b.size()), 128'd0);
    checkOutput("small_queue_empty", 128'(q_s.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
